// File: rtl/pcode_seq.sv
// Pseudocode ROM address sequencer: walks [start_addr, start_addr+length-1] at one chip per chip_div clocks.
// Optional epoch counter port enabled by defining PCODE_SEQ_EPOCH_CNT_EN.
module pcode_seq #(
    parameter int unsigned DEPTH = 20460,
    parameter int unsigned AW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] length,
    input  logic [15:0]   chip_div,
    output logic [AW-1:0] pcode_addr,
    input  logic          pcode_0,
    input  logic          pcode_1,
    input  logic          pcode_2,
    input  logic          pcode_3,
    input  logic          pcode_4,
    input  logic          pcode_5,
    input  logic          pcode_6,
    input  logic          pcode_7,
    output logic [7:0]    chip_bits,
    output logic          chip_valid,
    output logic          epoch,
    output logic          busy,
    output logic          cfg_err
`ifdef PCODE_SEQ_EPOCH_CNT_EN
    ,
    output logic [15:0]   epoch_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);

    state_t        state;
    logic [AW-1:0] base;
    logic [AW-1:0] last_addr;
    logic [AW-1:0] last_idx;
    logic [AW-1:0] idx;
    logic [15:0]   div;
    logic [15:0]   div_cnt;

    logic [AW:0]   end_sum;
    logic          cfg_ok;
    logic [7:0]    rom_dat;
    logic [AW-1:0] next_addr;
    logic          pre_tick;

    assign end_sum   = {1'b0, start_addr} + {1'b0, length};
    assign cfg_ok    = (length != '0) && (end_sum <= LIMIT);
    assign rom_dat   = {pcode_7, pcode_6, pcode_5, pcode_4,
                        pcode_3, pcode_2, pcode_1, pcode_0};
    assign next_addr = (pcode_addr == last_addr) ? base : pcode_addr + AW'(1);
    // The address must lead the chip being captured by one cycle, so it moves
    // in the cycle before each tick (always true in PRIME, and every cycle when div is 1).
    assign pre_tick  = (div_cnt == div - 16'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            base       <= '0;
            last_addr  <= '0;
            last_idx   <= '0;
            idx        <= '0;
            div        <= 16'd1;
            div_cnt    <= '0;
            pcode_addr <= '0;
            chip_bits  <= '0;
            chip_valid <= 1'b0;
            epoch      <= 1'b0;
            busy       <= 1'b0;
            cfg_err    <= 1'b0;
`ifdef PCODE_SEQ_EPOCH_CNT_EN
            epoch_cnt  <= '0;
`endif
        end else begin
            chip_valid <= 1'b0;
            epoch      <= 1'b0;
            cfg_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            base       <= start_addr;
                            last_addr  <= start_addr + length - AW'(1);
                            last_idx   <= length - AW'(1);
                            div        <= (chip_div == 16'd0) ? 16'd1 : chip_div;
                            pcode_addr <= start_addr;
                            idx        <= '0;
                            div_cnt    <= '0;
                            busy       <= 1'b1;
                            state      <= PRIME;
`ifdef PCODE_SEQ_EPOCH_CNT_EN
                            epoch_cnt  <= '0;
`endif
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                PRIME: begin
                    if (stop) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        pcode_addr <= next_addr;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        div_cnt <= pre_tick ? 16'd0 : div_cnt + 16'd1;
                        if (pre_tick) begin
                            pcode_addr <= next_addr;
                        end
                        if (div_cnt == 16'd0) begin
                            chip_bits  <= rom_dat;
                            chip_valid <= 1'b1;
                            if (idx == last_idx) begin
                                epoch <= 1'b1;
                                idx   <= '0;
`ifdef PCODE_SEQ_EPOCH_CNT_EN
                                epoch_cnt <= epoch_cnt + 16'd1;
`endif
                            end else begin
                                idx <= idx + AW'(1);
                            end
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcode_seq.sv
// Bench for pcode_seq: directed runs checked every cycle against a chip-index model, plus literal spot checks.
module tb_pcode_seq;

    localparam int BIG = 1 << 30;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic [15:0] start_addr;
    logic [15:0] length;
    logic [15:0] chip_div;
    logic [15:0] pcode_addr;
    logic [7:0]  rom_q;
    logic [7:0]  chip_bits;
    logic        chip_valid;
    logic        epoch;
    logic        busy;
    logic        cfg_err;
`ifdef PCODE_SEQ_EPOCH_CNT_EN
    logic [15:0] epoch_cnt;
`endif

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit chk_en = 0;

    // model: a run is the edge interval [m_t0, m_tend); chip j lands on edge m_t0+2+j*m_d
    int         m_t0   = 0;
    int         m_tend = 0;
    int         m_s    = 0;
    int         m_l    = 1;
    int         m_d    = 1;
    int         m_err  = -1;
    logic [7:0] m_bits = 8'h00;
    int         m_ecnt = 0;

    pcode_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .start_addr (start_addr),
        .length     (length),
        .chip_div   (chip_div),
        .pcode_addr (pcode_addr),
        .pcode_0    (rom_q[0]),
        .pcode_1    (rom_q[1]),
        .pcode_2    (rom_q[2]),
        .pcode_3    (rom_q[3]),
        .pcode_4    (rom_q[4]),
        .pcode_5    (rom_q[5]),
        .pcode_6    (rom_q[6]),
        .pcode_7    (rom_q[7]),
        .chip_bits  (chip_bits),
        .chip_valid (chip_valid),
        .epoch      (epoch),
        .busy       (busy),
        .cfg_err    (cfg_err)
`ifdef PCODE_SEQ_EPOCH_CNT_EN
        ,
        .epoch_cnt  (epoch_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_word(input int a);
        logic [15:0] w;
        w = a[15:0];
        return w[7:0] ^ w[15:8] ^ 8'hA5;
    endfunction

    // registered ROM: data in a cycle belongs to the previous cycle's address
    always @(posedge clk) rom_q <= rom_word(int'(pcode_addr));
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        bit act, v, ep, inwin;
        int j, a;
        if (chk_en) begin
            act = (cyc >= m_t0) && (cyc < m_tend);
            v = 0;
            ep = 0;
            if (act && cyc >= m_t0 + 2 && ((cyc - m_t0 - 2) % m_d) == 0) begin
                j  = (cyc - m_t0 - 2) / m_d;
                a  = m_s + (j % m_l);
                v  = 1;
                ep = ((j % m_l) == m_l - 1);
                m_bits = rom_word(a);
                if (ep) m_ecnt = (m_ecnt + 1) & 16'hFFFF;
            end
            chk("chip_valid", 32'(chip_valid), 32'(v));
            chk("epoch", 32'(epoch), 32'(ep));
            chk("busy", 32'(busy), 32'(act));
            chk("cfg_err", 32'(cfg_err), 32'(cyc == m_err));
            chk("chip_bits", 32'(chip_bits), 32'(m_bits));
`ifdef PCODE_SEQ_EPOCH_CNT_EN
            chk("epoch_cnt", 32'(epoch_cnt), 32'(m_ecnt));
`endif
            if (act) begin
                inwin = (int'(pcode_addr) >= m_s) && (int'(pcode_addr) <= m_s + m_l - 1);
                chk("addr_window", 32'(inwin), 32'd1);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_start(input int s, input int l, input int d, input bit with_stop);
        int e;
        bit idle;
        e = cyc + 1;
        idle = !((cyc >= m_t0) && (cyc < m_tend));
        start = 1'b1;
        stop = with_stop;
        start_addr = 16'(s);
        length = 16'(l);
        chip_div = 16'(d);
        if (idle) begin
            if (l != 0 && s + l <= 20460) begin
                m_t0 = e;
                m_tend = BIG;
                m_s = s;
                m_l = l;
                m_d = (d == 0) ? 1 : d;
                m_ecnt = 0;
            end else begin
                m_err = e;
            end
        end else if (with_stop) begin
            m_tend = e;
        end
        step();
        start = 1'b0;
        stop = 1'b0;
    endtask

    task automatic do_stop();
        if ((cyc >= m_t0) && (cyc < m_tend)) m_tend = cyc + 1;
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic do_reset();
        if (m_tend > cyc + 1) m_tend = cyc + 1;
        m_bits = 8'h00;
        m_ecnt = 0;
        m_err = -1;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        start_addr = '0;
        length = '0;
        chip_div = '0;
        step();
        chk_en = 1;
        step();
        rst = 1'b0;
        step();
        chk("reset_addr", 32'(pcode_addr), 32'h0);
        chk("reset_bits", 32'(chip_bits), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);

        // continuous pipeline over words 1023..2045 and back to 1023
        do_start(1023, 1023, 1, 0);
        chk("busy_after_start", 32'(busy), 32'h1);
        step();
        step();
        chk("first_chip_valid", 32'(chip_valid), 32'h1);
        chk("first_chip_bits", 32'(chip_bits), 32'h59);
        repeat (1022) step();
        chk("last_chip_bits", 32'(chip_bits), 32'h5F);
        chk("last_chip_epoch", 32'(epoch), 32'h1);
        step();
        chk("wrap_chip_bits", 32'(chip_bits), 32'h59);
        do_start(0, 5, 1, 0);
        repeat (6) step();
        do_stop();
        chk("stop_no_valid", 32'(chip_valid), 32'h0);
        repeat (3) step();
        do_stop();

        // chip_div 0 behaves as 1, then chip_div 5 with a stop on a tick edge
        do_start(100, 3, 0, 0);
        repeat (12) step();
        do_stop();
        do_start(200, 3, 5, 0);
        while (cyc < m_t0 + 31) step();
        do_stop();
        chk("stop_on_tick_valid", 32'(chip_valid), 32'h0);
        chk("stop_on_tick_busy", 32'(busy), 32'h0);
        step();

        // window validation at the top of the ROM
        do_start(20000, 461, 1, 0);
        chk("reject_cfg_err", 32'(cfg_err), 32'h1);
        chk("reject_busy", 32'(busy), 32'h0);
        step();
        do_start(5, 0, 3, 0);
        chk("len0_cfg_err", 32'(cfg_err), 32'h1);
        step();
        do_start(20000, 460, 1, 1);
        chk("start_stop_accept", 32'(busy), 32'h1);
        repeat (461) step();
        chk("top_word_bits", 32'(chip_bits), 32'h01);
        chk("top_word_epoch", 32'(epoch), 32'h1);
        repeat (2) step();
        do_stop();

        // epoch counting with length 2
        do_start(7, 2, 1, 0);
        repeat (11) step();
`ifdef PCODE_SEQ_EPOCH_CNT_EN
        chk("epoch_cnt_10_chips", 32'(epoch_cnt), 32'd5);
`endif
        do_stop();
        step();
        do_start(7, 2, 1, 0);
`ifdef PCODE_SEQ_EPOCH_CNT_EN
        chk("epoch_cnt_cleared", 32'(epoch_cnt), 32'd0);
`endif
        repeat (5) step();
        do_stop();

        // reset at chip 100 of a chip_div=4 run
        do_start(0, 1023, 4, 0);
        while (cyc < m_t0 + 401) step();
        do_reset();
        chk("rst_run_addr", 32'(pcode_addr), 32'h0);
        chk("rst_run_bits", 32'(chip_bits), 32'h0);
        chk("rst_run_valid", 32'(chip_valid), 32'h0);
        chk("rst_run_busy", 32'(busy), 32'h0);
        repeat (4) step();

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pcode_seq.md
# pcode_seq

Address sequencer and reader for the 8-channel pseudocode ROM. It walks a programmable address window of the ROM at a programmable chip rate and compensates the ROM's one-cycle registered read latency. It presents the 8 code bits per chip with a valid strobe and flags each code-period wrap (epoch). It sits between the ROM and the downstream spreading/correlation logic.

## Interface
- DEPTH, 20460, number of ROM words; highest legal address is DEPTH-1
- AW, 16, address width
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  single-cycle pulse; begins sequencing (honoured in IDLE only)
- stop  in  1  single-cycle pulse; aborts sequencing
- start_addr  in  AW  first ROM address of the window; latched on start
- length  in  AW  chips per code period; latched on start
- chip_div  in  16  clocks per chip; latched on start; 0 is treated as 1
- pcode_addr  out  AW  address to the ROM; registered
- pcode_0..pcode_7  in  1 each  ROM read data; valid one cycle after pcode_addr
- chip_bits  out  8  {pcode_7..pcode_0} of the current chip; registered
- chip_valid  out  1  one-cycle pulse when chip_bits is updated
- epoch  out  1  pulse coincident with the chip_valid of the last chip (index length-1)
- busy  out  1  high in PRIME and RUN
- cfg_err  out  1  one-cycle pulse when a start is rejected
- epoch_cnt  out  16  epochs since start; present only with PCODE_SEQ_EPOCH_CNT_EN

## Operation
- States: IDLE, PRIME, RUN.
- IDLE + start:
  - Validate: length != 0 and start_addr + length <= DEPTH, computed at AW+1 bits.
  - Invalid: cfg_err pulses next cycle; stay in IDLE; no other output changes.
  - Valid: latch the parameters; pcode_addr <= start_addr; chip index idx <= 0; div_cnt <= 0; go to PRIME.
- PRIME: lasts one cycle so ROM data for start_addr is ready. Then go to RUN.
- RUN: tick = (div_cnt == 0). div_cnt counts 0..chip_div-1 and wraps.
- On tick:
  - chip_bits <= ROM data.
  - chip_valid <= 1.
  - epoch <= (idx == length-1).
  - If idx == length-1: idx <= 0 and pcode_addr <= start_addr.
  - Otherwise: idx++ and pcode_addr++.
- ROM data at a tick always belongs to the pcode_addr value of the previous cycle. This holds for chip_div = 1, where the address advances every cycle as a continuous pipeline.
- The address never leaves [start_addr, start_addr+length-1]. length = 1 re-reads the same word and asserts epoch on every chip.
- stop in PRIME or RUN: go to IDLE next cycle. stop has priority over a tick in the same cycle, so no chip_valid or epoch is asserted. chip_bits and pcode_addr hold their values.
- start while busy: ignored. stop in IDLE: ignored. start and stop in the same IDLE cycle: start wins.
- rst at any time: all state returns to reset values next cycle, including mid-RUN.

## Timing
- Reset values: pcode_addr 0, chip_bits 0, chip_valid 0, epoch 0, busy 0, cfg_err 0, epoch_cnt 0; state IDLE.
- start in cycle T:
  - busy = 1 from T+1.
  - First chip_valid in T+2, carrying data for start_addr.
  - Subsequent chip_valid pulses every max(chip_div,1) cycles.
- chip_valid and epoch are single-cycle pulses, registered.
- stop in cycle T: busy = 0 in T+1; no chip_valid at or after T+1.

## Configuration
- PCODE_SEQ_EPOCH_CNT_EN defined:
  - epoch_cnt port exists.
  - Clears to 0 on each accepted start.
  - Increments in the same cycle epoch is asserted.
  - Wraps 0xFFFF -> 0.
  - Holds its value after stop.
- Not defined: the port and its counter are absent; all other behaviour is identical.

## Test plan
- Reset mid-RUN (start_addr=0, length=1023, chip_div=4), rst at chip 100 -> next cycle all outputs at reset values, state IDLE, busy 0.
- start_addr=1023, length=1023, chip_div=1 -> chip_valid pulses every cycle starting T+2; chip_bits match ROM words 1023..2045 in order; epoch on the chip from word 2045; next chip is from word 1023 again.
- chip_div=0 and chip_div=5, length=3 -> chip_div=0 behaves as 1; with chip_div=5, chip_valid is spaced exactly 5 cycles apart; epoch on every 3rd chip.
- Rejected starts: start_addr=20000, length=461 -> cfg_err pulse and busy stays 0. start_addr=20000, length=460 -> accepted, last address 20459. length=0 -> cfg_err.
- stop in the same cycle as a tick -> no chip_valid. start issued while busy -> ignored. start+stop together in IDLE -> accepted.
- With PCODE_SEQ_EPOCH_CNT_EN: length=2, chip_div=1, run 10 chips -> epoch_cnt=5. A new start clears it to 0.
